// File: rtl/jtcps1_pal_dma.sv
// Palette DMA: on each copy request, wins the VRAM bus through br/bg and copies
// the enabled 512-word pages from VRAM into the on-chip palette RAM.
module jtcps1_pal_dma #(
    parameter int PAGES   = 6,
    parameter int PAGE_AW = 9
) (
    input  logic                               clk,
    input  logic                               reg_rst,
    input  logic                               pal_copy,
    input  logic [15:0]                        pal_base,
    input  logic [PAGES-1:0]                   pal_page_en,
    output logic                               br,
    input  logic                               bg,
    output logic [16:0]                        vram_addr,
    output logic                               vram_cs,
    input  logic [15:0]                        vram_data,
    input  logic                               vram_ok,
    output logic                               pal_we,
    output logic [$clog2(PAGES)+PAGE_AW-1:0]   pal_addr,
    output logic [15:0]                        pal_data,
    output logic                               busy,
    output logic                               pal_done
);

    localparam int PW = $clog2(PAGES);
    localparam int CW = $clog2(PAGES + 1);
    localparam int EW = 1 << CW;

    typedef enum logic [2:0] {IDLE, SKIP, REQ, READ, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [9:0]              base_q, base_d;
    logic [PAGES-1:0]        en_q, en_d;
    logic [CW-1:0]           page_q, page_d, src_q, src_d;
    logic [PAGE_AW-1:0]      idx_q, idx_d;
    logic                    first_q, first_d;
    logic                    br_q, br_d, cs_q, cs_d, we_q, we_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [16:0]             addr_q, addr_d;
    logic [PW+PAGE_AW-1:0]   paddr_q, paddr_d;
    logic [15:0]             pdata_q, pdata_d;

    logic [EW-1:0]           enExt;
    logic                    pageLeft, pageOn, accept, okTake, enterRead;

    // Only the low ten bits of the base register select the VRAM source.
    logic                    unusedBase;
    assign unusedBase = ^pal_base[15:10];

    always_ff @(posedge clk or posedge reg_rst) begin
        if (reg_rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            base_q    <= '0;
            en_q      <= '0;
            page_q    <= '0;
            src_q     <= '0;
            idx_q     <= '0;
            first_q   <= 1'b0;
            br_q      <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            paddr_q   <= '0;
            pdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            en_q      <= en_d;
            page_q    <= page_d;
            src_q     <= src_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            br_q      <= br_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
        end
    end

    always_comb begin
        enExt            = '0;
        enExt[PAGES-1:0] = en_q;
        pageLeft         = (page_q < CW'(PAGES));
        pageOn           = enExt[page_q];
        accept           = (state_q == IDLE) && (pal_copy || pending_q);
        // The first ok cycle of every strobe may be stale from the previous read.
        okTake           = (state_q == READ) && !first_q && vram_ok;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (pal_page_en == '0) ? DONE : SKIP;
            SKIP:    if (!pageLeft) state_d = DONE;
                     else if (pageOn) state_d = REQ;
            REQ:     if (bg) state_d = READ;
            READ:    if (okTake) state_d = WRITE;
            WRITE:   if (&idx_q) state_d = SKIP;
                     else state_d = bg ? READ : REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d = accept ? 1'b0 : (pending_q | pal_copy);
        base_d    = base_q;
        en_d      = en_q;
        page_d    = page_q;
        src_d     = src_q;
        idx_d     = idx_q;
        pdata_d   = pdata_q;
        case (state_q)
            IDLE:  if (accept) begin
                       base_d = pal_base[9:0];
                       en_d   = pal_page_en;
                       page_d = '0;
                       src_d  = '0;
                   end
            SKIP:  if (pageLeft) begin
                       if (pageOn) idx_d = '0;
                       else page_d = page_q + CW'(1);
                   end
            READ:  if (okTake) pdata_d = vram_data;
            WRITE: if (&idx_q) begin
                       page_d = page_q + CW'(1);
                       src_d  = src_q + CW'(1);
                   end else begin
                       idx_d = idx_q + PAGE_AW'(1);
                   end
            default: ;
        endcase

        enterRead = (state_d == READ) && (state_q != READ);
        first_d   = enterRead ? 1'b1 : ((state_q == READ) ? 1'b0 : first_q);

        // br is held across page boundaries and only released when the copy ends.
        br_d = br_q;
        if (state_d == REQ) br_d = 1'b1;
        if (state_d == DONE || state_d == IDLE) br_d = 1'b0;

        cs_d   = (state_d == READ);
        addr_d = addr_q;
        if (enterRead)
            addr_d = {base_q, 7'd0} + 17'({src_d, {PAGE_AW{1'b0}}}) + 17'(idx_d);

        we_d    = (state_d == WRITE);
        paddr_d = paddr_q;
        if (state_d == WRITE) paddr_d = {page_q[PW-1:0], idx_q};

        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    assign br        = br_q;
    assign vram_cs   = cs_q;
    assign vram_addr = addr_q;
    assign pal_we    = we_q;
    assign pal_addr  = paddr_q;
    assign pal_data  = pdata_q;
    assign busy      = busy_q;
    assign pal_done  = done_q;

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Bench for jtcps1_pal_dma: a page-list model of each copy predicts every VRAM
// read address and palette write, checked cycle by cycle against the DUT.
module tb_jtcps1_pal_dma;

    logic        clk = 1'b0;
    logic        reg_rst = 1'b0;
    logic        pal_copy = 1'b0;
    logic [15:0] pal_base = '0;
    logic [5:0]  pal_page_en = '0;
    logic        br, bg = 1'b1;
    logic [16:0] vram_addr;
    logic        vram_cs, vram_ok;
    logic [15:0] vram_data;
    logic        pal_we;
    logic [11:0] pal_addr;
    logic [15:0] pal_data;
    logic        busy, pal_done;

    typedef struct packed {
        logic [11:0] pa;
        logic [15:0] pd;
        logic [16:0] va;
    } wr_t;

    wr_t         expQ[$];
    wr_t         cmpEntry;
    int          nCompared = 0, nMismatch = 0;
    int          weCount = 0, doneCount = 0, copiesOwed = 0;
    bit          pendValid = 0, captureCs = 0, bgForce = 0, bgRandom = 0;
    logic        prevBg = 1'b1, prevCs = 1'b0;
    logic [11:0] lastPa = '0;
    logic [15:0] lastPd = '0;
    logic [16:0] firstCsAddr = '0;
    int          okLat = 0, csAge = 0;

    jtcps1_pal_dma dut (
        .clk(clk), .reg_rst(reg_rst), .pal_copy(pal_copy), .pal_base(pal_base),
        .pal_page_en(pal_page_en), .br(br), .bg(bg), .vram_addr(vram_addr),
        .vram_cs(vram_cs), .vram_data(vram_data), .vram_ok(vram_ok),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .busy(busy), .pal_done(pal_done)
    );

    always #5 clk = ~clk;

    // VRAM returns its own address as data, okLat cycles into each strobe.
    always @(posedge clk) csAge <= vram_cs ? csAge + 1 : 0;
    assign vram_ok   = vram_cs && (csAge >= okLat);
    assign vram_data = vram_addr[15:0];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bgForce) bg = 1'b0;
            else if (bgRandom) bg = ($urandom_range(0, 7) != 0);
            else bg = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Enabled pages are packed back to back in VRAM from base*128; destination keeps the page number.
    task automatic modelQueueCopy(input logic [15:0] base, input logic [5:0] en);
        int  k;
        wr_t w;
        k = 0;
        for (int p = 0; p < 6; p++) begin
            if (en[p]) begin
                for (int i = 0; i < 512; i++) begin
                    w.va = 17'((int'(base[9:0]) * 128 + k * 512 + i) % 131072);
                    w.pa = 12'(p * 512 + i);
                    w.pd = w.va[15:0];
                    expQ.push_back(w);
                end
                k++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reg_rst) begin
            if (pal_we) begin
                weCount++;
                checkOutput("we_expected", 32'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    cmpEntry = expQ.pop_front();
                    checkOutput("pal_addr", 32'(pal_addr), 32'(cmpEntry.pa));
                    checkOutput("pal_data", 32'(pal_data), 32'(cmpEntry.pd));
                    lastPa = pal_addr;
                    lastPd = pal_data;
                end
            end
            if (vram_cs) begin
                if (expQ.size() != 0) checkOutput("vram_addr", 32'(vram_addr), 32'(expQ[0].va));
                else checkOutput("cs_expected", 0, 1);
                checkOutput("br_with_cs", 32'(br), 1);
                if (!prevCs) checkOutput("bg_before_cs", 32'(prevBg), 1);
                if (captureCs) begin
                    firstCsAddr = vram_addr;
                    captureCs   = 0;
                end
            end
            if (pal_done) begin
                doneCount++;
                checkOutput("queue_empty_at_done", expQ.size(), 0);
                checkOutput("done_expected", 32'(copiesOwed > 0), 1);
                if (copiesOwed > 0) copiesOwed--;
                if (pendValid) begin
                    pendValid = 0;
                    modelQueueCopy(pal_base, pal_page_en);
                end
            end
            if (copiesOwed == 0) checkOutput("br_idle", 32'(br), 0);
            prevBg = bg;
            prevCs = vram_cs;
        end else begin
            prevCs = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] base, input logic [5:0] en);
        pal_base    = base;
        pal_page_en = en;
        pal_copy    = 1'b1;
        if (copiesOwed == 0) begin
            modelQueueCopy(base, en);
            copiesOwed = 1;
        end else if (!pendValid) begin
            pendValid = 1;
            copiesOwed++;
        end
        tick();
        pal_copy = 1'b0;
    endtask

    task automatic waitDone(input int target, input int limit);
        int n = 0;
        while (doneCount < target && n < limit) begin
            tick();
            n++;
        end
        if (doneCount < target) checkOutput("done_timeout", doneCount, target);
    endtask

    task automatic waitWrites(input int target, input int limit);
        int n = 0;
        while (weCount < target && n < limit) begin
            tick();
            n++;
        end
        if (weCount < target) checkOutput("write_timeout", weCount, target);
    endtask

    initial begin
        int          startWe, d0, n, csGap;
        bit          brSeen;
        logic [15:0] rBase;
        logic [5:0]  rEn;

        #2 reg_rst = 1'b1;
        tick();
        checkOutput("rst_br", 32'(br), 0);
        checkOutput("rst_cs", 32'(vram_cs), 0);
        checkOutput("rst_we", 32'(pal_we), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(pal_done), 0);
        checkOutput("rst_vaddr", 32'(vram_addr), 0);
        checkOutput("rst_paddr", 32'(pal_addr), 0);
        checkOutput("rst_pdata", 32'(pal_data), 0);
        tick();
        reg_rst = 1'b0;
        repeat (3) tick();

        // Full six-page copy from base 0x0040.
        startWe = weCount; d0 = doneCount; captureCs = 1;
        applyStimulus(16'h0040, 6'h3f);
        checkOutput("model_full_size", expQ.size(), 3072);
        checkOutput("busy_after_req", 32'(busy), 1);
        waitDone(d0 + 1, 20000);
        checkOutput("done_one_cycle", 32'(pal_done), 0);
        checkOutput("full_first_vaddr", 32'(firstCsAddr), 32'h02000);
        checkOutput("full_writes", weCount - startWe, 3072);
        checkOutput("full_last_paddr", 32'(lastPa), 32'hBFF);
        checkOutput("full_last_pdata", 32'(lastPd), 32'h2BFF);
        checkOutput("full_busy_end", 32'(busy), 0);
        repeat (3) tick();

        // Sparse mask: pages 0 and 2 packed contiguously in VRAM.
        startWe = weCount; d0 = doneCount;
        applyStimulus(16'h0000, 6'b000101);
        checkOutput("model_sparse_size", expQ.size(), 1024);
        waitDone(d0 + 1, 10000);
        checkOutput("sparse_writes", weCount - startWe, 1024);
        checkOutput("sparse_last_paddr", 32'(lastPa), 32'h5FF);
        checkOutput("sparse_last_pdata", 32'(lastPd), 32'h03FF);
        repeat (3) tick();

        // Empty mask completes without touching the bus.
        startWe = weCount; d0 = doneCount; brSeen = 0;
        applyStimulus(16'h0123, 6'h00);
        n = 1;
        while (!pal_done && n < 10) begin
            if (br) brSeen = 1;
            tick();
            n++;
        end
        checkOutput("empty_done_latency", n, 2);
        checkOutput("empty_br_never", 32'(brSeen), 0);
        checkOutput("empty_writes", weCount - startWe, 0);
        repeat (3) tick();

        // Grant withdrawn for 20 cycles at page 1 index 100.
        startWe = weCount; d0 = doneCount; csGap = 0;
        applyStimulus(16'h1234, 6'h3f);
        waitWrites(startWe + 612, 20000);
        bgForce = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i >= 5 && vram_cs) csGap++;
        end
        checkOutput("gap_writes", weCount - startWe, 613);
        checkOutput("gap_no_cs", csGap, 0);
        checkOutput("gap_br_held", 32'(br), 1);
        checkOutput("gap_busy", 32'(busy), 1);
        bgForce = 0;
        waitDone(d0 + 1, 20000);
        checkOutput("gap_total_writes", weCount - startWe, 3072);
        repeat (3) tick();

        // Two extra requests during a copy merge into one queued copy with a fresh snapshot.
        startWe = weCount; d0 = doneCount;
        applyStimulus(16'h0200, 6'h2D);
        waitWrites(startWe + 200, 10000);
        applyStimulus(16'h0100, 6'h3f);
        repeat (5) tick();
        applyStimulus(16'h0100, 6'h3f);
        checkOutput("queued_copies", copiesOwed, 2);
        waitDone(d0 + 1, 20000);
        captureCs = 1;
        waitDone(d0 + 2, 20000);
        checkOutput("second_first_vaddr", 32'(firstCsAddr), 32'h08000);
        repeat (100) tick();
        checkOutput("two_copies_only", doneCount - d0, 2);
        checkOutput("merge_writes", weCount - startWe, 2048 + 3072);
        checkOutput("merge_busy_end", 32'(busy), 0);

        // Reset in the middle of a copy aborts it.
        startWe = weCount; d0 = doneCount;
        applyStimulus(16'h0080, 6'h3f);
        waitWrites(startWe + 700, 10000);
        reg_rst = 1'b1;
        #1;
        checkOutput("abort_br", 32'(br), 0);
        checkOutput("abort_cs", 32'(vram_cs), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        expQ.delete();
        copiesOwed = 0;
        pendValid  = 0;
        repeat (3) tick();
        reg_rst = 1'b0;
        repeat (50) tick();
        checkOutput("abort_writes", weCount - startWe, 700);
        checkOutput("abort_no_done", doneCount - d0, 0);
        checkOutput("abort_idle_busy", 32'(busy), 0);

        // Randomized copies with grant jitter and ok latency; the second wraps the VRAM address.
        for (int r = 0; r < 2; r++) begin
            okLat    = $urandom_range(0, 2);
            bgRandom = 1;
            rBase    = (r == 0) ? 16'($urandom) : 16'hF3FF;
            rEn      = 6'($urandom_range(1, 63));
            startWe  = weCount; d0 = doneCount;
            applyStimulus(rBase, rEn);
            waitDone(d0 + 1, 30000);
            checkOutput("rand_writes", weCount - startWe, $countones(rEn) * 512);
            repeat (3) tick();
        end
        bgRandom = 0;
        okLat    = 0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
